// File: rtl/nz_index_sequencer.sv
// Serialises a match vector into a stream of set-bit indices, lowest first,
// one beat per cycle over valid/ready, and reports the vector's popcount.
module nz_index_sequencer #(
    parameter int SIZE  = 128,
    parameter int IDX_W = $clog2(SIZE)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             match_valid_i,
    output logic             match_ready_o,
    input  logic [SIZE-1:0]  match_i,
    output logic             idx_valid_o,
    input  logic             idx_ready_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o,
    output logic             empty_o,
    output logic [IDX_W:0]   nz_cnt_o,
    output logic             busy_o
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] pend_q, pend_d;
    logic            empty_q, empty_d;
    logic [IDX_W:0]  nz_cnt_q, nz_cnt_d;

    logic [IDX_W-1:0] low_idx;
    logic             found;
    logic [SIZE-1:0]  pend_lowclr;
    logic             one_hot;
    logic [IDX_W:0]   pop;

    // Lowest set bit of the held vector; drives idx_o directly.
    always_comb begin
        low_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            if (pend_q[i] && !found) begin
                low_idx = IDX_W'(i);
                found   = 1'b1;
            end
        end
    end

    // x & (x-1) drops the lowest set bit; a zero result means one bit remained.
    assign pend_lowclr = pend_q & (pend_q - SIZE'(1));
    assign one_hot     = (pend_q != '0) && (pend_lowclr == '0);

    always_comb begin
        pop = '0;
        for (int i = 0; i < SIZE; i++) begin
            pop = pop + (IDX_W+1)'(match_i[i]);
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        empty_d       = empty_q;
        nz_cnt_d      = nz_cnt_q;
        match_ready_o = 1'b0;
        idx_valid_o   = 1'b0;
        idx_o         = '0;
        last_o        = 1'b0;
        empty_o       = 1'b0;
        case (state_q)
            IDLE: begin
                match_ready_o = 1'b1;
                if (match_valid_i) begin
                    pend_d   = match_i;
                    nz_cnt_d = pop;
                    empty_d  = (match_i == '0);
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                idx_valid_o = 1'b1;
                idx_o       = low_idx;
                last_o      = empty_q | one_hot;
                empty_o     = empty_q;
                if (idx_ready_i) begin
                    pend_d = pend_lowclr;
                    if (last_o) begin
                        state_d = IDLE;
                        empty_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            empty_q  <= 1'b0;
            nz_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            empty_q  <= empty_d;
            nz_cnt_q <= nz_cnt_d;
        end
    end

    assign nz_cnt_o = nz_cnt_q;
    assign busy_o   = (state_q == EMIT);

endmodule

// File: tb/tb_nz_index_sequencer.sv
// Directed bench for nz_index_sequencer: expected beats are queued when a
// vector is offered and popped as the DUT hands beats downstream.
module tb_nz_index_sequencer;

    localparam int SIZE  = 128;
    localparam int IDX_W = $clog2(SIZE);

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             match_valid_i = 1'b0;
    logic             match_ready_o;
    logic [SIZE-1:0]  match_i = '0;
    logic             idx_valid_o;
    logic             idx_ready_i = 1'b0;
    logic [IDX_W-1:0] idx_o;
    logic             last_o;
    logic             empty_o;
    logic [IDX_W:0]   nz_cnt_o;
    logic             busy_o;

    nz_index_sequencer #(.SIZE(SIZE)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .match_valid_i(match_valid_i),
        .match_ready_o(match_ready_o),
        .match_i      (match_i),
        .idx_valid_o  (idx_valid_o),
        .idx_ready_i  (idx_ready_i),
        .idx_o        (idx_o),
        .last_o       (last_o),
        .empty_o      (empty_o),
        .nz_cnt_o     (nz_cnt_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             last;
        logic             empty;
    } beat_t;

    beat_t exp_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: compare every accepted beat against the queue head.
    always @(negedge clk_i) begin : monitor
        beat_t e;
        if (rst_ni && idx_valid_o && idx_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {31'b0, idx_valid_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("idx",   {25'b0, idx_o},   {25'b0, e.idx});
                check("last",  {31'b0, last_o},  {31'b0, e.last});
                check("empty", {31'b0, empty_o}, {31'b0, e.empty});
            end
        end
    end

    function automatic int popcnt(input logic [SIZE-1:0] v);
        int n = 0;
        for (int i = 0; i < SIZE; i++) n += int'(v[i]);
        return n;
    endfunction

    // Offer one vector, queue its expected beats, and check the accept-side outputs.
    task automatic send(input logic [SIZE-1:0] v);
        int    cnt = 0;
        int    n   = popcnt(v);
        int    k   = 0;
        beat_t b;
        while (!match_ready_o && cnt < 400) begin
            @(posedge clk_i); #1; cnt++;
        end
        check("accept_ready", {31'b0, match_ready_o}, 32'd1);
        match_valid_i = 1'b1;
        match_i       = v;
        if (n == 0) begin
            b.idx = '0; b.last = 1'b1; b.empty = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                if (v[i]) begin
                    k++;
                    b.idx = IDX_W'(i); b.last = (k == n); b.empty = 1'b0;
                    exp_q.push_back(b);
                end
            end
        end
        @(posedge clk_i); #1;
        match_valid_i = 1'b0;
        match_i       = {$urandom(), $urandom(), $urandom(), $urandom()};
        check("nz_cnt", {24'b0, nz_cnt_o}, n);
        check("busy_after_accept", {31'b0, busy_o}, 32'd1);
        check("ready_low_in_emit", {31'b0, match_ready_o}, 32'd0);
    endtask

    task automatic drain(input bit rnd_ready);
        int cnt = 0;
        while ((exp_q.size() != 0 || !match_ready_o) && cnt < 1000) begin
            if (rnd_ready) idx_ready_i = 1'($urandom_range(0, 1));
            @(posedge clk_i); #1; cnt++;
        end
        idx_ready_i = 1'b1;
        check("drain_remaining", exp_q.size(), 32'd0);
        check("idle_after_drain", {31'b0, busy_o}, 32'd0);
    endtask

    initial begin
        logic [SIZE-1:0] v;

        // Reset held with random inputs
        for (int c = 0; c < 4; c++) begin
            match_valid_i = 1'($urandom_range(0, 1));
            idx_ready_i   = 1'($urandom_range(0, 1));
            match_i       = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk_i); #1;
        end
        check("rst_idx_valid", {31'b0, idx_valid_o},   32'd0);
        check("rst_ready",     {31'b0, match_ready_o}, 32'd1);
        check("rst_nz_cnt",    {24'b0, nz_cnt_o},      32'd0);
        check("rst_busy",      {31'b0, busy_o},        32'd0);
        check("rst_outs",      {29'b0, last_o, empty_o, |idx_o}, 32'd0);
        match_valid_i = 1'b0;
        idx_ready_i   = 1'b1;
        #2 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Sparse vector: bits 0, 5, 127 on consecutive cycles
        v = '0; v[0] = 1'b1; v[5] = 1'b1; v[127] = 1'b1;
        send(v);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("sparse_ready_n3", {31'b0, match_ready_o}, 32'd0);
        @(posedge clk_i); #1;
        check("sparse_ready_n4", {31'b0, match_ready_o}, 32'd1);
        check("sparse_queue", exp_q.size(), 32'd0);

        // Zero vector: single empty beat, two cycles total
        send('0);
        check("zero_last", {31'b0, last_o}, 32'd1);
        @(posedge clk_i); #1;
        check("zero_back_idle", {31'b0, match_ready_o}, 32'd1);
        check("zero_nz_cnt", {24'b0, nz_cnt_o}, 32'd0);

        // Backpressure on first beat of bits 3 and 64
        idx_ready_i = 1'b0;
        v = '0; v[3] = 1'b1; v[64] = 1'b1;
        send(v);
        for (int c = 0; c < 4; c++) begin
            check("bp_valid", {31'b0, idx_valid_o}, 32'd1);
            check("bp_idx",   {25'b0, idx_o},       32'd3);
            check("bp_last",  {31'b0, last_o},      32'd0);
            @(posedge clk_i); #1;
        end
        idx_ready_i = 1'b1;
        drain(1'b0);

        // Full vector, with upstream pushing another vector during EMIT
        send('1);
        match_valid_i = 1'b1;
        match_i       = 128'h1;
        for (int c = 0; c < 100; c++) begin
            check("full_ready_low", {31'b0, match_ready_o}, 32'd0);
            @(posedge clk_i); #1;
        end
        match_valid_i = 1'b0;
        check("full_nz_cnt", {24'b0, nz_cnt_o}, 32'd128);
        drain(1'b0);

        // Random sparse vectors under random backpressure
        for (int r = 0; r < 4; r++) begin
            v = {$urandom(), $urandom(), $urandom(), $urandom()} &
                {$urandom(), $urandom(), $urandom(), $urandom()} &
                {$urandom(), $urandom(), $urandom(), $urandom()};
            send(v);
            drain(1'b1);
        end

        // Reset in the middle of a 5-beat vector
        v = '0; v[1] = 1'b1; v[9] = 1'b1; v[40] = 1'b1; v[77] = 1'b1; v[126] = 1'b1;
        send(v);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("mid_two_done", exp_q.size(), 32'd3);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, idx_valid_o},   32'd0);
        check("mid_rst_busy",  {31'b0, busy_o},        32'd0);
        check("mid_rst_ready", {31'b0, match_ready_o}, 32'd1);
        exp_q.delete();
        #4 rst_ni = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            check("post_rst_quiet", {31'b0, idx_valid_o}, 32'd0);
        end
        v = '0; v[2] = 1'b1; v[100] = 1'b1;
        send(v);
        drain(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/nz_index_sequencer.md
Name: nz_index_sequencer

Overview:
- Consumes the SIZE-bit match vector produced by the bitwise IFM/filter AND stage.
- Serialises the vector into a stream of set-bit indices, lowest index first, one per cycle, over a valid/ready handshake.
- Sits between the AND stage and the MAC/weight-fetch control, so that only matching (nonzero) positions are processed.
- Also reports the popcount of each accepted vector.

Parameters:
- SIZE, 128, width of the match vector; must be ≥2.
- IDX_W, $clog2(SIZE), width of the emitted index; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- match_valid_i  input  1  match vector valid.
- match_ready_o  output  1  sequencer can accept a vector.
- match_i  input  SIZE  match vector (IFM & filter).
- idx_valid_o  output  1  idx_o/last_o/empty_o valid.
- idx_ready_i  input  1  downstream accepts the index beat.
- idx_o  output  IDX_W  position of the current set bit.
- last_o  output  1  current beat is the final beat for this vector.
- empty_o  output  1  accepted vector was all-zero; the beat carries no index.
- nz_cnt_o  output  IDX_W+1  popcount of the most recently accepted vector.
- busy_o  output  1  vector held (FSM in EMIT).

Behaviour:
- Reset is asynchronous (rst_ni low):
  - FSM goes to IDLE; pending register pend clears to 0.
  - idx_valid_o=0, idx_o=0, last_o=0, empty_o=0, nz_cnt_o=0, busy_o=0, match_ready_o=1 after reset.
  - Any vector in flight is discarded; no further beats for it after release.
- FSM has two states, IDLE and EMIT.
- IDLE:
  - match_ready_o=1, idx_valid_o=0.
  - Accept when match_valid_i & match_ready_o at edge N: pend<=match_i; nz_cnt_o<=popcount(match_i); empty flag<=(match_i==0); go to EMIT.
- EMIT:
  - match_ready_o=0 (no overlap between vectors).
  - idx_valid_o=1 from cycle N+1; first index is valid in the cycle after acceptance (latency 1).
  - idx_o = index of the lowest set bit of pend, combinational priority encode from the registered pend.
  - last_o=1 when pend has exactly one set bit, or when the empty flag is set.
  - empty_o=1 only for the all-zero case: exactly one beat with idx_o=0, last_o=1.
  - On handshake (idx_valid_o & idx_ready_i): clear the lowest set bit of pend. If last_o, return to IDLE, clear the empty flag, and assert match_ready_o in the next cycle.
- Throughput: popcount beats per nonzero vector plus 1 idle cycle; 2 cycles per zero vector.
- Backpressure: while idx_valid_o & !idx_ready_i, the outputs idx_o, last_o and empty_o hold stable, and pend does not change.
- match_i changes after acceptance are ignored.
- nz_cnt_o holds until the next acceptance; busy_o equals (state==EMIT).
- Index range is 0..SIZE-1; bit SIZE-1 set yields idx_o=SIZE-1; an all-ones vector yields SIZE beats, with nz_cnt_o=SIZE (needs IDX_W+1 bits).
- match_valid_i asserted during EMIT is not accepted; upstream must hold it until match_ready_o.
- idx_ready_i is allowed to be high with idx_valid_o low; this has no effect.

Test Plan:
- Reset value check: hold rst_ni=0 with random inputs. Required: idx_valid_o=0, match_ready_o=1, nz_cnt_o=0, busy_o=0. Then assert rst_ni asynchronously mid-cycle and check the outputs clear immediately.
- Sparse vector: match_i with bits 0, 5, 127 set, idx_ready_i=1. Required: beats idx 0, 5, 127 on consecutive cycles N+1..N+3; last_o only on 127; nz_cnt_o=3; match_ready_o high again at N+4.
- Zero vector: match_i=0. Required: one beat with empty_o=1, last_o=1, idx_o=0, nz_cnt_o=0; FSM returns to IDLE.
- Backpressure: vector with bits 3 and 64 set; idx_ready_i low for 4 cycles on the first beat. Required: idx_o=3 held stable, no skipped or duplicated index, then 64 with last_o=1.
- Full vector: all SIZE=128 bits set. Required: 128 beats, idx 0..127 in order, last_o on 127, nz_cnt_o=128; match_ready_o=0 throughout EMIT even with match_valid_i=1.
- Reset mid-operation: rst_ni pulsed low after 2 of 5 beats. Required: idx_valid_o drops at once; none of the remaining 3 indices appear; the next vector is accepted normally.
